config_loader: RTL
==================

Name: config_loader

Overview:
- Sequencer for a config_tile shift chain.
- Accepts a configuration bitstream as words over a valid/ready stream and serializes it MSB-first onto the tile's hard or soft shift input, driving shift_enable.
- After the last chain bit it issues the one-cycle commit strobe(s) (set_hard / set_soft) that transfer the chain into the config latches.
- Sits between the tile-array configuration port (bus/JTAG bridge) and each config_tile.

Parameters:
- CHAIN_LEN, 12: number of bits shifted into the tile chain per load.
- WORD_W, 8: input word width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  begin a load; sampled only in IDLE.
- hard_sel  in  1  1: route stream to shift_in_hard; 0: route to shift_in_soft. Latched on start.
- mem_update  in  1  soft loads only: 1 also commits memory config. Latched on start.
- in_data  in  WORD_W  bitstream word, MSB first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a word this cycle.
- shift_enable  out  1  to tile.
- shift_in_hard  out  1  to tile; 0 when not selected or not shifting.
- shift_in_soft  out  1  to tile; 0 when not selected or not shifting.
- set_hard  out  1  commit strobe to tile.
- set_soft  out  1  commit strobe to tile.
- busy  out  1  high from the cycle after start is accepted through COMMIT.
- done  out  1  one-cycle pulse in the cycle after COMMIT.
- err  out  1  parity error, sticky until next start; tied 0 without the option.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, all outputs 0, counters cleared. No set strobe is ever issued after a mid-load reset.
- NBITS = CHAIN_LEN (+1 with parity option). NWORDS = ceil(NBITS/WORD_W). Bits of the last word beyond NBITS are ignored.
- FSM, Moore outputs decoded from registered state/datapath:
  - IDLE: start=1 → latch hard_sel/mem_update, clear bit count and err, go to FETCH. start is ignored in any other state.
  - FETCH: in_ready=1. On in_valid & in_ready, load in_data into the shift register and go to SHIFT. in_valid=0 stalls with shift_enable=0; the chain holds.
  - SHIFT: shift_enable=1; the selected shift_in = shift register MSB; shift left each cycle; total bit count++.
    - Word exhausted and count < NBITS → FETCH.
    - Count == CHAIN_LEN (parity bit, if enabled, is consumed without asserting shift_enable) → COMMIT.
  - COMMIT, one cycle, shift_enable=0:
    - hard_sel=1 → set_hard=1 only.
    - hard_sel=0, mem_update=1 → set_soft=1 and set_hard=1.
    - hard_sel=0, mem_update=0 → set_soft=1 only.
    - Then IDLE with done=1 for one cycle.
- Latency with in_valid held high, defaults: start accepted at edge 0; FETCH, 8×SHIFT, FETCH, 4×SHIFT, COMMIT occupy cycles 1–15; done=1 in cycle 16.
- Bit counter width is $clog2(NBITS+1). Word bit counter width is $clog2(WORD_W+1). No wrap: the count saturates at NBITS by construction.
- start asserted in the same cycle done is high is accepted, giving back-to-back loads.

Optional Feature:
- Macro: CONFIG_PARITY_EN.
- When defined, stream bit CHAIN_LEN (the bit after the last chain bit) is an even-parity bit over the CHAIN_LEN chain bits.
  - It is not shifted into the chain (shift_enable=0 for that bit).
  - On mismatch: COMMIT asserts no set strobes, err=1 (sticky), done still pulses.
- When undefined: NBITS=CHAIN_LEN and err is tied to 0.

Decomposition:
- Shared package (config_pkg): FSM state encodings (IDLE, FETCH, SHIFT, COMMIT), NBITS/NWORDS derivation, and counter-width constants.
- One natural sub-module: config_word_serializer (WORD_W shift register plus word bit counter, load/shift/empty interface). The FSM and commit decode stay in config_loader.

Test Plan:
- Hard load, words 8'h3E, 8'h00 (stream 12'b001111100000), in_valid=1 → shift_in_hard sequence 0,0,1,1,1,1,1,0,0,0,0,0; shift_in_soft=0; set_hard pulse alone in cycle 15; done in cycle 16.
- Soft load, mem_update=1, words 8'hE1, 8'hD0 → shift_in_soft 111000011101; set_soft and set_hard high together for one cycle.
- Soft load, mem_update=0, words 8'hAA, 8'hB0 → shift_in_soft 101010101011; set_soft only, set_hard stays 0.
- Backpressure: in_valid low 3 cycles before word 2 → shift_enable low those cycles, chain bits unchanged; done in cycle 19.
- rst=0 during the 5th SHIFT cycle → next cycle all outputs 0, state IDLE; no set strobe; a new start then loads correctly.
- With CONFIG_PARITY_EN: words 8'h3E, 8'h08 → set_hard pulse, err=0. Words 8'h3E, 8'h00 → no set strobe, err=1, done pulses.

Source files
------------

// File: rtl/config_pkg.sv
// config_pkg: shared FSM encoding and size helpers for the config_tile loader.
// Optional feature macro: CONFIG_PARITY_EN (a trailing even-parity bit follows the chain bits).
package config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

`ifdef CONFIG_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Total stream bits consumed per load: the chain plus the optional parity bit.
  function automatic int calc_nbits(input int chain_len);
    return chain_len + PARITY_BITS;
  endfunction

  // Words needed to carry the stream; surplus bits of the last word are ignored.
  function automatic int calc_nwords(input int nbits, input int word_w);
    return (nbits + word_w - 1) / word_w;
  endfunction

  // Width of a counter that must hold values 0..max_count.
  function automatic int count_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/config_word_serializer.sv
// config_word_serializer: holds one stream word and presents it MSB-first,
// with a countdown of the bits still left in the word.
module config_word_serializer
  import config_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              msb,
  output logic              last
);

  localparam int               CNT_W = count_width(WORD_W);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [WORD_W-1:0] sreg_q;
  logic [CNT_W-1:0]  cnt_q;

  // Load a fresh word, or shift left by one and count the bit down.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      sreg_q <= data;
      cnt_q  <= FULL;
    end else if (shift && (cnt_q != '0)) begin
      sreg_q <= {sreg_q[WORD_W-2:0], 1'b0};
      cnt_q  <= cnt_q - ONE;
    end
  end

  assign msb  = sreg_q[WORD_W-1];
  assign last = (cnt_q == ONE);

endmodule

// File: rtl/config_loader.sv
// config_loader: fetches a configuration bitstream word by word, shifts it MSB-first
// into a config_tile hard or soft chain, then pulses the matching commit strobe(s).
// Optional feature macro: CONFIG_PARITY_EN (checks a trailing even-parity bit; a
// mismatch suppresses the commit and raises a sticky err).
module config_loader
  import config_pkg::*;
#(
  parameter int CHAIN_LEN = 12,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hard_sel,
  input  logic              mem_update,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              shift_enable,
  output logic              shift_in_hard,
  output logic              shift_in_soft,
  output logic              set_hard,
  output logic              set_soft,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                   NBITS     = calc_nbits(CHAIN_LEN);
  localparam int                   BIT_CNT_W = count_width(NBITS);
  localparam logic [BIT_CNT_W-1:0] NBITS_C   = BIT_CNT_W'(NBITS);
  localparam logic [BIT_CNT_W-1:0] CHAIN_C   = BIT_CNT_W'(CHAIN_LEN);
  localparam logic [BIT_CNT_W-1:0] ONE_C     = BIT_CNT_W'(1);

  state_t               state_q, state_d;
  logic                 hard_q, mem_q, done_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_inc;
  logic                 ser_load, ser_shift, ser_msb, ser_last;
  logic                 start_acc, chain_phase, commit_ok;

  assign start_acc   = (state_q == ST_IDLE) && start;
  assign bit_cnt_inc = bit_cnt_q + ONE_C;
  assign chain_phase = (bit_cnt_q < CHAIN_C);

  config_word_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load),
    .shift (ser_shift),
    .data  (in_data),
    .msb   (ser_msb),
    .last  (ser_last)
  );

  // State register, load options captured on start, stream bit count and done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      hard_q    <= 1'b0;
      mem_q     <= 1'b0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_COMMIT);
      if (start_acc) begin
        hard_q    <= hard_sel;
        mem_q     <= mem_update;
        bit_cnt_q <= '0;
      end else if (state_q == ST_SHIFT) begin
        bit_cnt_q <= bit_cnt_inc;
      end
    end
  end

  // Next-state logic plus the serializer load/shift controls.
  always_comb begin
    state_d   = state_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (in_valid) begin
          ser_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ser_shift = 1'b1;
        if (bit_cnt_inc == NBITS_C) state_d = ST_COMMIT;
        else if (ser_last)          state_d = ST_FETCH;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef CONFIG_PARITY_EN
  logic parity_q, err_q;

  // Accumulate chain parity, then compare it with the bit that follows the chain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (start_acc) begin
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (state_q == ST_SHIFT) begin
      if (chain_phase) parity_q <= parity_q ^ ser_msb;
      else             err_q    <= (ser_msb != parity_q);
    end
  end

  assign err       = err_q;
  assign commit_ok = ~err_q;
`else
  assign err       = 1'b0;
  assign commit_ok = 1'b1;
`endif

  assign in_ready      = (state_q == ST_FETCH);
  assign shift_enable  = (state_q == ST_SHIFT) && chain_phase;
  assign shift_in_hard = shift_enable &  hard_q & ser_msb;
  assign shift_in_soft = shift_enable & ~hard_q & ser_msb;
  assign set_hard      = (state_q == ST_COMMIT) & commit_ok & (hard_q | mem_q);
  assign set_soft      = (state_q == ST_COMMIT) & commit_ok & ~hard_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;

endmodule
